// File: rtl/mips16_pkg.sv
// Shared encodings for the 16-bit MIPS multicycle core.
// States, opcodes, ALU op codes and the control-strobe bundle.
package mips16_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADDR  = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC     = 4'd6,
    ST_RWB      = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9
  } state_e;

  localparam logic [3:0] OP_LOAD   = 4'b1000;
  localparam logic [3:0] OP_STORE  = 4'b1001;
  localparam logic [3:0] OP_BRANCH = 4'b1010;
  localparam logic [3:0] OP_JUMP   = 4'b1011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  typedef struct packed {
    logic [1:0] op_alu;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

endpackage

// File: rtl/mips16_main_control.sv
// Multicycle main control FSM: sequences fetch/decode/execute/mem/wb,
// stalls on mem_ready and counts retired instructions.
module mips16_main_control
  import mips16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       Opcode,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic [1:0]       OpAlu,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_e             state_q, state_d;
  logic               run_q, run_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire;
  ctrl_t              c, cg;

  always_comb begin
    c         = '0;
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    run_d     = 1'b1;
    unique case (state_q)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.op_alu    = ALU_ADD;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        c.alu_src_b = 2'b10;
        if (!Opcode[3]) begin
          state_d = ST_EXEC;
        end else begin
          unique case (Opcode)
            OP_LOAD,
            OP_STORE:  state_d = ST_MEMADDR;
            OP_BRANCH: state_d = ST_BRANCH;
            OP_JUMP:   state_d = ST_JUMP;
            default: begin
              state_d   = ST_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      ST_MEMADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d = (Opcode == OP_STORE) ?
                  ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_MEMWRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXEC: begin
        c.alu_src_a = 1'b1;
        c.op_alu    = ALU_R;
        state_d = ST_RWB;
      end
      ST_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.op_alu        = ALU_BR;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
    // Hold in FETCH until the first edge after reset release.
    if (!run_q) begin
      state_d   = ST_FETCH;
      illegal_d = 1'b0;
      retire    = 1'b0;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
    cg    = run_q ? c : '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_FETCH;
      run_q     <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign state       = state_q;
  assign OpAlu       = cg.op_alu;
  assign PCWrite     = cg.pc_write;
  assign PCWriteCond = cg.pc_write_cond;
  assign PCSource    = cg.pc_source;
  assign IorD        = cg.iord;
  assign MemRead     = cg.mem_read;
  assign MemWrite    = cg.mem_write;
  assign IRWrite     = cg.ir_write;
  assign MemtoReg    = cg.mem_to_reg;
  assign RegDst      = cg.reg_dst;
  assign RegWrite    = cg.reg_write;
  assign ALUSrcA     = cg.alu_src_a;
  assign ALUSrcB     = cg.alu_src_b;
  assign illegal_op  = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips16_main_control.sv
// Self-checking bench for mips16_main_control (CNT_W=16 and CNT_W=4).
// Per-cycle vectors feed a scoreboard checked at the falling edge.
module tb_mips16_main_control;

  typedef struct packed {
    logic [1:0] op_alu;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
  } ctl_t;

  typedef struct {
    logic [3:0] op;
    logic       mr;
    logic [3:0] st;
    logic       off;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    ctl_t       ctl;
    logic       ill;
  } exp_t;

  logic        clock, resetn, mem_ready;
  logic [3:0]  Opcode;
  logic [3:0]  state, state4;
  logic [1:0]  OpAlu, PCSource, ALUSrcB;
  logic [1:0]  OpAlu4, PCSource4, ALUSrcB4;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic        PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4;
  logic        IRWrite4, MemtoReg4, RegDst4, RegWrite4, ALUSrcA4;
  logic        illegal_op, illegal_op4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  exp_t sb[$];
  vec_t tbl[$];

  mips16_main_control #(.CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .Opcode(Opcode),
    .mem_ready(mem_ready), .state(state), .OpAlu(OpAlu),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  mips16_main_control #(.CNT_W(4)) dut4 (
    .clock(clock), .resetn(resetn), .Opcode(Opcode),
    .mem_ready(mem_ready), .state(state4), .OpAlu(OpAlu4),
    .PCWrite(PCWrite4), .PCWriteCond(PCWriteCond4),
    .PCSource(PCSource4), .IorD(IorD4), .MemRead(MemRead4),
    .MemWrite(MemWrite4), .IRWrite(IRWrite4),
    .MemtoReg(MemtoReg4), .RegDst(RegDst4),
    .RegWrite(RegWrite4), .ALUSrcA(ALUSrcA4),
    .ALUSrcB(ALUSrcB4), .illegal_op(illegal_op4),
    .instr_count(instr_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  ctl_t got, got4;
  assign got  = '{OpAlu, PCWrite, PCWriteCond, PCSource,
                  IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB};
  assign got4 = '{OpAlu4, PCWrite4, PCWriteCond4, PCSource4,
                  IorD4, MemRead4, MemWrite4, IRWrite4,
                  MemtoReg4, RegDst4, RegWrite4, ALUSrcA4,
                  ALUSrcB4};

  // Strobe table written from the state descriptions.
  function automatic ctl_t strobes(input logic [3:0] st,
                                   input logic mr,
                                   input logic off);
    ctl_t e;
    e = '0;
    if (!off) begin
      case (st)
        4'd0: begin
          e.mem_read = 1; e.alu_src_b = 2'b01;
          e.ir_write = mr; e.pc_write = mr;
        end
        4'd1: e.alu_src_b = 2'b10;
        4'd2: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
        4'd3: begin e.mem_read = 1; e.iord = 1; end
        4'd4: begin e.reg_write = 1; e.mem_to_reg = 1; end
        4'd5: begin e.mem_write = 1; e.iord = 1; end
        4'd6: begin e.alu_src_a = 1; e.op_alu = 2'b10; end
        4'd7: begin e.reg_write = 1; e.reg_dst = 1; end
        4'd8: begin
          e.alu_src_a = 1; e.op_alu = 2'b01;
          e.pc_write_cond = 1; e.pc_source = 2'b01;
        end
        4'd9: begin e.pc_write = 1; e.pc_source = 2'b10; end
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input int g, input int x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, g, x);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic mr,
                     input logic [3:0] st, input logic off,
                     input logic ill);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.off = off; v.ill = ill;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    Opcode = v.op;
    mem_ready = v.mr;
    e.st = v.st;
    e.ctl = strobes(v.st, v.mr, v.off);
    e.ill = v.ill;
    sb.push_back(e);
    @(negedge clock);
    e = sb.pop_front();
    chk("state", int'(state), int'(e.st));
    chk("state4", int'(state4), int'(e.st));
    chk("strobes", int'(got), int'(e.ctl));
    chk("strobes4", int'(got4), int'(e.ctl));
    chk("illegal_op", int'(illegal_op), int'(e.ill));
    @(posedge clock);
    #1;
  endtask

  task automatic play();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic chk_cnt(input string name);
    chk(name, int'(instr_count), exp_cnt & 16'hffff);
    chk({name, "4"}, int'(instr_count4), exp_cnt & 4'hf);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    add(4'h0, 1'b1, 4'd0, 1'b1, 1'b0);
    play();
    exp_cnt = 0;
    chk_cnt("cnt_reset");
    resetn = 1'b1;
    add(4'h0, 1'b1, 4'd0, 1'b1, 1'b0);
    play();
  endtask

  task automatic rtype(input logic [3:0] op);
    add(op, 1, 4'd0, 0, 0);
    add(op, 1, 4'd1, 0, 0);
    add(op, 1, 4'd6, 0, 0);
    add(op, 1, 4'd7, 0, 0);
    play();
    exp_cnt++;
  endtask

  initial begin
    resetn = 1'b0;
    Opcode = 4'h0;
    mem_ready = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    rtype(4'b0010);
    chk_cnt("cnt_rtype");

    add(4'b1000, 0, 4'd0, 0, 0);
    add(4'b1000, 0, 4'd0, 0, 0);
    add(4'b1000, 1, 4'd0, 0, 0);
    add(4'b1000, 1, 4'd1, 0, 0);
    add(4'b1000, 1, 4'd2, 0, 0);
    add(4'b1000, 0, 4'd3, 0, 0);
    add(4'b1000, 0, 4'd3, 0, 0);
    add(4'b1000, 0, 4'd3, 0, 0);
    add(4'b1000, 1, 4'd3, 0, 0);
    add(4'b1000, 1, 4'd4, 0, 0);
    add(4'b1000, 0, 4'd0, 0, 0);
    play();
    exp_cnt++;
    chk_cnt("cnt_load");

    add(4'b1001, 1, 4'd0, 0, 0);
    add(4'b1001, 1, 4'd1, 0, 0);
    add(4'b1001, 1, 4'd2, 0, 0);
    add(4'b1001, 1, 4'd5, 0, 0);
    add(4'b1001, 1, 4'd0, 0, 0);
    add(4'b1001, 1, 4'd1, 0, 0);
    add(4'b1001, 1, 4'd2, 0, 0);
    add(4'b1001, 0, 4'd5, 0, 0);
    add(4'b1001, 0, 4'd5, 0, 0);
    add(4'b1001, 1, 4'd5, 0, 0);
    play();
    exp_cnt += 2;
    chk_cnt("cnt_store");

    add(4'b1010, 1, 4'd0, 0, 0);
    add(4'b1010, 1, 4'd1, 0, 0);
    add(4'b1010, 1, 4'd8, 0, 0);
    add(4'b1011, 1, 4'd0, 0, 0);
    add(4'b1011, 1, 4'd1, 0, 0);
    add(4'b1011, 1, 4'd9, 0, 0);
    play();
    exp_cnt += 2;
    chk_cnt("cnt_brjmp");

    add(4'b1110, 1, 4'd0, 0, 0);
    add(4'b1110, 1, 4'd1, 0, 0);
    add(4'b1110, 0, 4'd0, 0, 1);
    add(4'b1110, 0, 4'd0, 0, 0);
    play();
    chk_cnt("cnt_illegal");

    add(4'b1000, 1, 4'd0, 0, 0);
    add(4'b1000, 1, 4'd1, 0, 0);
    add(4'b1000, 1, 4'd2, 0, 0);
    add(4'b1000, 0, 4'd3, 0, 0);
    play();
    chk("pre_reset_state", int'(state), 3);
    resetn = 1'b0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_strobes", int'(got), 0);
    exp_cnt = 0;
    chk_cnt("cnt_midrst");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    add(4'b1000, 0, 4'd0, 1, 0);
    add(4'b1000, 0, 4'd0, 0, 0);
    play();
    chk("post_rst_memread", int'(MemRead), 1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      rtype(4'(i % 8));
      chk_cnt("cnt_wrap");
    end
    chk("wrap4_zero", int'(instr_count4), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mips16_main_control.md
Name: mips16_main_control

Overview:
Multicycle main control FSM for the 16-bit MIPS core. It sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback. It drives the 2-bit OpAlu and 4-bit state consumed by the ALU-control stage, and all datapath strobes. It also stalls on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  system clock; FSM updates on rising edge
resetn  in  1  asynchronous active-low reset
Opcode  in  4  IR[15:12]; 0000-0111 R-type, 1000 load, 1001 store, 1010 branch, 1011 jump, 1100-1111 illegal
mem_ready  in  1  memory completes current access this cycle
state  out  4  current FSM state encoding
OpAlu  out  2  00 add, 01 branch compare (subtract), 10 R-type (use Opcode)
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
PCSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target
IorD  out  1  0 address=PC, 1 address=ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load
MemtoReg  out  1  regfile write data from MDR
RegDst  out  1  1 rd field, 0 rt field
RegWrite  out  1  regfile write
ALUSrcA  out  1  0 PC, 1 regA
ALUSrcB  out  2  00 regB, 01 const 1, 10 sign-ext imm, 11 reserved
illegal_op  out  1  one-cycle pulse on illegal opcode
instr_count  out  CNT_W  retired instructions

Behaviour:
- resetn low (async): state=FETCH(0000); run flag=0; instr_count=0; illegal_op=0.
- All strobes except state are gated by the run flag, so they read 0 during reset and in the first cycle after release. The run flag sets to 1 at the first rising edge after resetn goes high.
- Outputs are Moore decodes of state. The only exceptions are FETCH/MEMREAD/MEMWRITE qualifiers on mem_ready, listed below.
- States and transitions:
  - FETCH 0000: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, OpAlu=00, PCSource=00. IRWrite=PCWrite=mem_ready. mem_ready=1 -> DECODE, else stay.
  - DECODE 0001: ALUSrcA=0, ALUSrcB=10, OpAlu=00 (precompute branch target).
    - Opcode 0xxx -> EXEC; 1000/1001 -> MEMADDR; 1010 -> BRANCH; 1011 -> JUMP.
    - 11xx -> FETCH, with illegal_op=1 in the next cycle only; not counted as retired.
  - MEMADDR 0010: ALUSrcA=1, ALUSrcB=10, OpAlu=00. Load -> MEMREAD, store -> MEMWRITE.
  - MEMREAD 0011: MemRead=1, IorD=1. mem_ready -> MEMWB, else stay.
  - MEMWB 0100: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWRITE 0101: MemWrite=1, IorD=1. mem_ready -> FETCH, else stay. MemWrite stays asserted while waiting.
  - EXEC 0110: ALUSrcA=1, ALUSrcB=00, OpAlu=10 -> RWB.
  - RWB 0111: RegWrite=1, MemtoReg=0, RegDst=1 -> FETCH.
  - BRANCH 1000: ALUSrcA=1, ALUSrcB=00, OpAlu=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - JUMP 1001: PCWrite=1, PCSource=10 -> FETCH.
  - Encodings 1010-1111 are unreachable; if entered -> FETCH, no strobes.
- Any strobe not listed for a state is 0.
- instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, RWB, BRANCH or JUMP. It wraps modulo 2^CNT_W.
- Opcode is sampled only in DECODE and MEMADDR; it must be stable from IR load onward.
- Reset mid-access (e.g. in MEMREAD) aborts immediately, and all strobes drop asynchronously.

Decomposition:
- Shared package mips16_pkg holds:
  - state encodings (ST_FETCH..ST_JUMP);
  - opcode constants (OP_LOAD=1000, OP_STORE=1001, OP_BRANCH=1010, OP_JUMP=1011);
  - OpAlu codes (ALU_ADD=00, ALU_BR=01, ALU_R=10).
- No sub-module: the next-state logic, output decode and counter fit in one module.

Test Plan:
- R-type: reset, Opcode=0010, mem_ready=1 -> state 0000,0001,0110,0111,0000. OpAlu=10 in 0110; RegWrite=1, RegDst=1 in 0111; instr_count=1.
- Load with wait: Opcode=1000, mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> FETCH held 3 cycles, IRWrite only on the last. MEMREAD held 4 cycles with IorD=1. MEMWB has MemtoReg=1; total 11 cycles.
- Store: Opcode=1001, mem_ready=1 -> 0000,0001,0010,0101,0000. MemWrite=1 only in 0101.
- Branch/jump: Opcode=1010 -> 1000 with PCWriteCond=1, PCSource=01, OpAlu=01. Opcode=1011 -> 1001 with PCWrite=1, PCSource=10. instr_count increments by 2.
- Illegal: Opcode=1110 -> DECODE to FETCH, illegal_op high exactly 1 cycle, instr_count unchanged.
- Reset mid-MEMREAD with mem_ready=0 -> all strobes 0 immediately and state=0000. First cycle after release has no strobes; the second cycle has MemRead=1. instr_count=0.
- Counter wrap: CNT_W=4, 16 R-type instructions -> instr_count returns to 0.
